uart_console_fifo: RTL and testbench
====================================

// Module: uart_console_fifo
// PURPOSE
//  Parametrised console buffer between the Z80 I/O decode and the uart_tx/uart_rx
//  cores. Replaces the fixed 128-byte TX ring with configurable TX and RX FIFOs,
//  CPU strobe edge detection, UART handshake sequencing, sticky overflow flags
//  and a status byte for CONSTA. Runs entirely on sys_clk.
// PARAMETERS
//  DATA_W     8  payload width
//  TX_AW      7  log2 TX depth (2^TX_AW entries, all usable)
//  RX_AW      4  log2 RX depth
//  SYNC_EN    1  1: 2-flop sync on cpu_wr/cpu_rd; 0: inputs already in sys_clk domain
// PORTS
//  sys_clk     in   1       system clock
//  reset       in   1       asynchronous, active-high
//  cpu_wr      in   1       level strobe, CPU write to CONDAT; rising edge = push TX
//  cpu_wr_data in   DATA_W  byte sampled at the detected rising edge of cpu_wr
//  cpu_rd      in   1       level strobe, CPU read of CONDAT; rising edge = pop RX
//  clr_flags   in   1       1-cycle pulse, clears both overflow flags
//  tx_data     out  DATA_W  to uart_tx
//  tx_send     out  1       to uart_tx, request
//  tx_ready    in   1       from uart_tx, low while transmitting
//  rx_data     in   DATA_W  from uart_rx
//  rx_data_ready in 1       from uart_rx, byte valid
//  rx_clear    out  1       to uart_rx, acknowledge
//  rx_head     out  DATA_W  RX FIFO head (CONDAT read value); 0 when empty
//  status      out  8       {tx_ovf, rx_ovf, 2'b0, tx_empty, tx_not_full, 1'b0, rx_not_empty}
//  tx_count    out  TX_AW+1 TX occupancy;  rx_count out RX_AW+1 RX occupancy
// BEHAVIOUR
//  Reset: FIFOs empty, counts 0, tx_send=0, tx_data=0, rx_clear=0, flags 0,
//   status=8'h0C, FSMs IDLE. Reset mid-transfer aborts; buffered data lost.
//  Edge detect: rise = s_q & ~s_qq after sync (SYNC_EN=1 adds 2 cycles latency);
//   one push/pop per edge regardless of strobe length.
//  TX push: on wr rise, if tx_count<2^TX_AW write tail, tail++; else drop, tx_ovf<=1.
//   Pointers TX_AW bits, wrap naturally; count distinguishes full/empty.
//  TX FSM: IDLE -(count>0 & tx_ready)-> LOAD: tx_data<=head, head++, tx_send<=1
//   -> BUSY: hold tx_send until tx_ready=0, then tx_send<=0 -> DONE: wait
//   tx_ready=1 -> IDLE. Push and pop in same cycle: count unchanged.
//  RX FSM: IDLE -(rx_data_ready)-> CAPT: if rx_count<2^RX_AW push rx_data else
//   rx_ovf<=1 (byte discarded, newest lost) -> ACK: rx_clear=1 until
//   rx_data_ready=0, then rx_clear<=0 -> IDLE. Never captures one byte twice.
//  RX pop: on rd rise if rx_count>0 head++; empty pop ignored (no flag).
//   rx_head is combinational from head so CPU sees data before the rd edge.
//  Same-cycle RX push and pop: both apply, count unchanged; full+pop+push ok.
//  Flags sticky; clr_flags wins over a same-cycle set.
//  status bits registered-free (derived from counts/flags), valid same cycle.
// TESTING
//  1 reset, no activity -> status=8'h0C, tx_send=0, rx_clear=0, counts 0.
//  2 push 0x41,0x42,0x43 with tx_ready model (low 20 cycles per byte) -> tx_data
//    sequence 41,42,43, one tx_send pulse each, tx_count back to 0, status[3]=1.
//  3 TX_AW=2: push 5 bytes with tx_ready held 0 -> tx_count=4, status[7]=1,
//    bytes 1-4 sent in order after tx_ready=1; clr_flags -> status[7]=0.
//  4 RX: 3 rx_data_ready handshakes (0x10,0x20,0x30) -> rx_clear per byte,
//    rx_count=3, rx_head=10; three cpu_rd edges -> 20,30, then status[0]=0.
//  5 RX_AW=1: 3 bytes, no reads -> rx_count=2, rx_ovf=1, rx_head=first byte;
//    cpu_wr held high 50 cycles -> exactly one TX push.
//  6 assert reset during TX BUSY and RX ACK -> all outputs to reset values
//    immediately (asynchronous); normal traffic resumes after release.

Source files
------------

// File: rtl/uart_console_fifo.sv
// Console buffer between the Z80 CONDAT/CONSTA decode and the uart_tx/uart_rx cores.
// TX and RX FIFOs with strobe edge detection, UART handshake sequencing,
// sticky overflow flags and a CONSTA status byte. Single clock domain (sys_clk).
module uart_console_fifo #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TX_AW   = 7,
    parameter int unsigned RX_AW   = 4,
    parameter bit          SYNC_EN = 1'b1
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_rd,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_send,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_data_ready,
    output logic              rx_clear,
    output logic [DATA_W-1:0] rx_head,
    output logic [7:0]        status,
    output logic [TX_AW:0]    tx_count,
    output logic [RX_AW:0]    rx_count
);

    localparam int unsigned TX_DEPTH = 2 ** TX_AW;
    localparam int unsigned RX_DEPTH = 2 ** RX_AW;

    localparam logic [TX_AW:0]   TX_FULL    = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW:0]   RX_FULL    = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW + 1)'(1);
    localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW + 1)'(1);
    localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
    localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);

    typedef enum logic [1:0] {TxIdle, TxLoad, TxBusy, TxDone} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxCapt, RxAck} rx_state_e;

    // ------------------------------------------------------------------
    // Strobe synchronisation and rising-edge detection, bit 0 = wr, bit 1 = rd
    // ------------------------------------------------------------------
    logic [1:0] strb_sync;
    logic [1:0] strb_q, strb_qq;
    logic       wr_rise, rd_rise;

    if (SYNC_EN) begin : g_sync
        logic [1:0] strb_meta_q, strb_sync_q;

        // Two-flop synchroniser for the CPU strobes
        always_ff @(posedge sys_clk or posedge reset) begin
            if (reset) begin
                strb_meta_q <= 2'b00;
                strb_sync_q <= 2'b00;
            end else begin
                strb_meta_q <= {cpu_rd, cpu_wr};
                strb_sync_q <= strb_meta_q;
            end
        end
        assign strb_sync = strb_sync_q;
    end else begin : g_nosync
        assign strb_sync = {cpu_rd, cpu_wr};
    end

    // Delay line for edge detection
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            strb_q  <= 2'b00;
            strb_qq <= 2'b00;
        end else begin
            strb_q  <= strb_sync;
            strb_qq <= strb_q;
        end
    end

    assign wr_rise = strb_q[0] & ~strb_qq[0];
    assign rd_rise = strb_q[1] & ~strb_qq[1];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] tx_mem [0:TX_DEPTH-1];
    logic [TX_AW-1:0]  tx_head_q, tx_tail_q;
    logic [TX_AW:0]    tx_count_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_send_q;
    logic              tx_ovf_q;
    tx_state_e         tx_state_q;
    logic              tx_full, tx_push, tx_pop;

    assign tx_full = (tx_count_q == TX_FULL);
    assign tx_push = wr_rise & ~tx_full;
    assign tx_pop  = (tx_state_q == TxIdle) & (tx_count_q != '0) & tx_ready;

    // TX storage write, no reset needed on the array
    always_ff @(posedge sys_clk) begin
        if (tx_push) begin
            tx_mem[tx_tail_q] <= cpu_wr_data;
        end
    end

    // TX tail pointer, occupancy and sticky overflow flag
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            tx_tail_q  <= '0;
            tx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_tail_q <= tx_tail_q + TX_PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count_q <= tx_count_q + TX_CNT_ONE;
                2'b01:   tx_count_q <= tx_count_q - TX_CNT_ONE;
                default: tx_count_q <= tx_count_q;
            endcase
            if (clr_flags) begin
                tx_ovf_q <= 1'b0;
            end else if (wr_rise && tx_full) begin
                tx_ovf_q <= 1'b1;
            end
        end
    end

    // TX handshake FSM: pop a byte, raise tx_send until uart_tx goes busy, wait idle
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_head_q  <= '0;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TxIdle: begin
                    if (tx_pop) begin
                        tx_data_q  <= tx_mem[tx_head_q];
                        tx_head_q  <= tx_head_q + TX_PTR_ONE;
                        tx_send_q  <= 1'b1;
                        tx_state_q <= TxLoad;
                    end
                end
                TxLoad: tx_state_q <= TxBusy;
                TxBusy: begin
                    if (!tx_ready) begin
                        tx_send_q  <= 1'b0;
                        tx_state_q <= TxDone;
                    end
                end
                TxDone: begin
                    if (tx_ready) begin
                        tx_state_q <= TxIdle;
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_send  = tx_send_q;
    assign tx_count = tx_count_q;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_mem [0:RX_DEPTH-1];
    logic [RX_AW-1:0]  rx_head_q, rx_tail_q;
    logic [RX_AW:0]    rx_count_q;
    logic              rx_clear_q;
    logic              rx_ovf_q;
    rx_state_e         rx_state_q;
    logic              rx_full, rx_capt, rx_push, rx_pop;

    assign rx_full = (rx_count_q == RX_FULL);
    assign rx_capt = (rx_state_q == RxCapt);
    assign rx_pop  = rd_rise & (rx_count_q != '0);
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
    assign rx_push = rx_capt & (~rx_full | rx_pop);

    // RX storage write
    always_ff @(posedge sys_clk) begin
        if (rx_push) begin
            rx_mem[rx_tail_q] <= rx_data;
        end
    end

    // RX pointers, occupancy and sticky overflow flag
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rx_head_q  <= '0;
            rx_tail_q  <= '0;
            rx_count_q <= '0;
            rx_ovf_q   <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_tail_q <= rx_tail_q + RX_PTR_ONE;
            end
            if (rx_pop) begin
                rx_head_q <= rx_head_q + RX_PTR_ONE;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count_q <= rx_count_q + RX_CNT_ONE;
                2'b01:   rx_count_q <= rx_count_q - RX_CNT_ONE;
                default: rx_count_q <= rx_count_q;
            endcase
            if (clr_flags) begin
                rx_ovf_q <= 1'b0;
            end else if (rx_capt && !rx_push) begin
                rx_ovf_q <= 1'b1;
            end
        end
    end

    // RX handshake FSM: capture once, hold rx_clear until uart_rx drops ready
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RxIdle;
            rx_clear_q <= 1'b0;
        end else begin
            case (rx_state_q)
                RxIdle: begin
                    if (rx_data_ready) begin
                        rx_state_q <= RxCapt;
                    end
                end
                RxCapt: begin
                    rx_clear_q <= 1'b1;
                    rx_state_q <= RxAck;
                end
                RxAck: begin
                    if (!rx_data_ready) begin
                        rx_clear_q <= 1'b0;
                        rx_state_q <= RxIdle;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    assign rx_clear = rx_clear_q;
    assign rx_count = rx_count_q;
    assign rx_head  = (rx_count_q != '0) ? rx_mem[rx_head_q] : '0;

    assign status = {tx_ovf_q, rx_ovf_q, 2'b00, (tx_count_q == '0), ~tx_full,
                     1'b0, (rx_count_q != '0)};

endmodule

// File: tb/tb_uart_console_fifo.sv
// Randomised scoreboard bench for uart_console_fifo with small FIFOs (TX 4, RX 2).
module tb_uart_console_fifo;

    localparam int TX_AW    = 2;
    localparam int RX_AW    = 1;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 2;

    logic             sys_clk = 1'b0;
    logic             reset;
    logic             cpu_wr, cpu_rd, clr_flags;
    logic [7:0]       cpu_wr_data;
    logic [7:0]       tx_data;
    logic             tx_send, tx_ready;
    logic [7:0]       rx_data;
    logic             rx_data_ready, rx_clear;
    logic [7:0]       rx_head, status;
    logic [TX_AW:0]   tx_count;
    logic [RX_AW:0]   rx_count;

    uart_console_fifo #(
        .DATA_W (8),
        .TX_AW  (TX_AW),
        .RX_AW  (RX_AW),
        .SYNC_EN(1'b1)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .cpu_wr       (cpu_wr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_rd       (cpu_rd),
        .clr_flags    (clr_flags),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_clear     (rx_clear),
        .rx_head      (rx_head),
        .status       (status),
        .tx_count     (tx_count),
        .rx_count     (rx_count)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passes = 0;
    int tx_sends = 0;

    // Reference model: plain queues of bytes plus sticky flags
    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_model[$];
    bit         tx_ovf_m, rx_ovf_m;

    // uart_tx model controls
    bit hold, no_ack;
    int busy, busy_len;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [7:0] exp_status(input int tx_occ);
        return {tx_ovf_m, rx_ovf_m, 2'b00, tx_occ == 0, tx_occ < TX_DEPTH, 1'b0,
                rx_model.size() != 0};
    endfunction

    // uart_tx model: drops tx_ready for a while after each accepted request
    initial begin
        tx_ready = 1'b1;
        busy = 0;
        forever begin
            @(negedge sys_clk);
            if (reset) begin
                tx_ready = 1'b1;
                busy = 0;
            end else if (hold) begin
                tx_ready = 1'b0;
                busy = 0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) tx_ready = 1'b1;
            end else if (tx_send && tx_ready && !no_ack) begin
                tx_ready = 1'b0;
                busy = (busy_len > 0) ? busy_len : int'($urandom_range(3, 20));
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // TX monitor: every new tx_send request must carry the next expected byte
    initial begin
        bit prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (tx_send && !prev) begin
                    tx_sends++;
                    if (tx_exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL tx_unexpected: got %0h want none at %0t", tx_data, $time);
                    end else begin
                        chk("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
                    end
                end
                prev = tx_send;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_tx(input logic [7:0] d);
        cpu_wr_data = d;
        if (!hold || tx_exp_q.size() < TX_DEPTH) tx_exp_q.push_back(d);
        else tx_ovf_m = 1'b1;
        cpu_wr = 1'b1;
        cyc($urandom_range(1, 4));
        cpu_wr = 1'b0;
        cyc(4);
    endtask

    task automatic drain_tx;
        int t = 0;
        while ((tx_exp_q.size() != 0 || tx_count != 0 || tx_send || !tx_ready) && t < 3000) begin
            cyc(1);
            t++;
        end
        chk("tx_drain_count", 32'(tx_count), 0);
        chk("tx_drain_left", 32'(tx_exp_q.size()), 0);
        cyc(2);
    endtask

    task automatic send_rx(input logic [7:0] d);
        int t = 0;
        rx_data = d;
        rx_data_ready = 1'b1;
        while (!rx_clear && t < 50) begin
            cyc(1);
            t++;
        end
        chk("rx_clear_ack", 32'(rx_clear), 1);
        if (rx_model.size() < RX_DEPTH) rx_model.push_back(d);
        else rx_ovf_m = 1'b1;
        rx_data_ready = 1'b0;
        t = 0;
        while (rx_clear && t < 50) begin
            cyc(1);
            t++;
        end
        chk("rx_clear_release", 32'(rx_clear), 0);
        rx_data = 8'($urandom);
        cyc(1);
    endtask

    task automatic read_rx;
        logic [7:0] e;
        e = (rx_model.size() != 0) ? rx_model[0] : 8'h00;
        chk("rx_head", 32'(rx_head), 32'(e));
        cpu_rd = 1'b1;
        cyc($urandom_range(1, 4));
        cpu_rd = 1'b0;
        cyc(4);
        if (rx_model.size() != 0) void'(rx_model.pop_front());
    endtask

    task automatic pulse_clr;
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        tx_ovf_m = 1'b0;
        rx_ovf_m = 1'b0;
        cyc(1);
    endtask

    initial begin
        int n, sends0, t;
        reset = 1'b1;
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        clr_flags = 1'b0;
        cpu_wr_data = 8'h00;
        rx_data = 8'h00;
        rx_data_ready = 1'b0;
        hold = 1'b0;
        no_ack = 1'b0;
        busy_len = 0;
        tx_ovf_m = 1'b0;
        rx_ovf_m = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(3);

        // Idle after reset
        chk("rst_status", 32'(status), 32'h0C);
        chk("rst_tx_send", 32'(tx_send), 0);
        chk("rst_rx_clear", 32'(rx_clear), 0);
        chk("rst_tx_count", 32'(tx_count), 0);
        chk("rst_rx_count", 32'(rx_count), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_rx_head", 32'(rx_head), 0);

        // Fixed three-byte transmit with a 20-cycle busy uart
        busy_len = 20;
        push_tx(8'h41);
        push_tx(8'h42);
        push_tx(8'h43);
        drain_tx();
        chk("tx_three_sends", 32'(tx_sends), 3);
        chk("tx_three_status", 32'(status), 32'(exp_status(0)));
        busy_len = 0;

        // Held uart: fill, possibly overflow, then release and drain
        for (int r = 0; r < 6; r++) begin
            hold = 1'b1;
            cyc(2);
            n = (r == 0) ? 5 : int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) push_tx(8'($urandom));
            chk("tx_held_count", 32'(tx_count), 32'(tx_exp_q.size()));
            chk("tx_held_status", 32'(status), 32'(exp_status(tx_exp_q.size())));
            hold = 1'b0;
            drain_tx();
            chk("tx_post_status", 32'(status), 32'(exp_status(0)));
            pulse_clr();
            chk("tx_clr_status", 32'(status), 32'(exp_status(0)));
        end

        // Receive: fixed bytes first, then random batches, some overflowing
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? 3 : int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                if (r == 0) send_rx(8'(8'h10 * (i + 1)));
                else send_rx(8'($urandom));
            end
            chk("rx_fill_count", 32'(rx_count), 32'(rx_model.size()));
            chk("rx_fill_status", 32'(status), 32'(exp_status(0)));
            n = rx_model.size() + 1;
            for (int i = 0; i < n; i++) read_rx();
            chk("rx_empty_count", 32'(rx_count), 0);
            chk("rx_empty_status", 32'(status), 32'(exp_status(0)));
            pulse_clr();
            chk("rx_clr_status", 32'(status), 32'(exp_status(0)));
        end

        // Long write strobe counts as a single push
        hold = 1'b1;
        cyc(2);
        sends0 = tx_sends;
        cpu_wr_data = 8'($urandom);
        tx_exp_q.push_back(cpu_wr_data);
        cpu_wr = 1'b1;
        cyc(50);
        cpu_wr = 1'b0;
        cyc(4);
        chk("tx_long_strobe_count", 32'(tx_count), 1);
        hold = 1'b0;
        drain_tx();
        chk("tx_long_strobe_sends", 32'(tx_sends - sends0), 1);

        // Asynchronous reset while TX is in BUSY and RX is in ACK
        no_ack = 1'b1;
        push_tx(8'h5A);
        t = 0;
        while (!tx_send && t < 100) begin
            cyc(1);
            t++;
        end
        chk("busy_tx_send", 32'(tx_send), 1);
        push_tx(8'h6B);
        rx_data = 8'h77;
        rx_data_ready = 1'b1;
        t = 0;
        while (!rx_clear && t < 50) begin
            cyc(1);
            t++;
        end
        chk("ack_rx_clear", 32'(rx_clear), 1);
        @(negedge sys_clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_tx_send", 32'(tx_send), 0);
        chk("arst_tx_data", 32'(tx_data), 0);
        chk("arst_rx_clear", 32'(rx_clear), 0);
        chk("arst_status", 32'(status), 32'h0C);
        chk("arst_tx_count", 32'(tx_count), 0);
        chk("arst_rx_count", 32'(rx_count), 0);
        chk("arst_rx_head", 32'(rx_head), 0);
        tx_exp_q.delete();
        rx_model.delete();
        tx_ovf_m = 1'b0;
        rx_ovf_m = 1'b0;
        no_ack = 1'b0;
        rx_data_ready = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(3);

        // Traffic resumes after reset
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        drain_tx();
        send_rx(8'($urandom));
        send_rx(8'($urandom));
        chk("resume_rx_count", 32'(rx_count), 2);
        read_rx();
        read_rx();
        chk("resume_status", 32'(status), 32'(exp_status(0)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
